prs_hdr_capture: RTL and testbench
==================================

# prs_hdr_capture

Ingress stage directly upstream of the programmable parser. It accepts packet beats on a 512-bit AXI-stream and forwards every beat unchanged to the packet store. In parallel it captures the leading bytes of each packet into a 4096-bit header buffer and presents that buffer to the parser, together with byte length, truncation flag and packet sequence number, over a valid/ready handshake.

## Interface
- `DATA_W`, 512: stream data width in bits.
- `KEEP_W`, `DATA_W/8`: byte-enable width.
- `BUFF_W`, 4096: header buffer width in bits. Must be an integer multiple of `DATA_W`. `NBEATS = BUFF_W/DATA_W` (8 by default).
- `LEN_W`, 32: width of `hdr_len`.
- `PKT_NUM_W`, 64: width of the packet sequence counter.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `s_axis_tdata` / `tkeep` / `tvalid` / `tlast`  in  `DATA_W` / `KEEP_W` / 1 / 1  — ingress packet stream.
- `s_axis_tready`  out  1  — ingress ready.
- `m_axis_tdata` / `tkeep` / `tvalid` / `tlast`  out  `DATA_W` / `KEEP_W` / 1 / 1  — pass-through to packet store.
- `m_axis_tready`  in  1  — packet store ready.
- `hdr_data`  out  `BUFF_W`  — captured header. Beat i occupies `[i*DATA_W +: DATA_W]`.
- `hdr_len`  out  `LEN_W`  — number of valid bytes in `hdr_data` (0..`BUFF_W/8`).
- `hdr_trunc`  out  1  — packet was longer than `NBEATS` beats.
- `hdr_pkt_num`  out  `PKT_NUM_W`  — sequence number of this packet.
- `hdr_valid`  out  1 / `hdr_ready`  in  1  — header handshake.

## Operation
- State register `st` has three states:
  - SOP: next accepted beat is the first beat of a packet.
  - CAPT: beats 1..`NBEATS-1` are being captured.
  - DRAIN: beats beyond `NBEATS` are forwarded only.
- Gate: `blk = (st==SOP) && hdr_valid && !hdr_ready`.
  - `s_axis_tready = m_axis_tready && !blk`.
  - `m_axis_tvalid = s_axis_tvalid && !blk`.
  - m_axis data, keep and last are wired straight through from s_axis.
- A beat is accepted when `s_axis_tvalid && s_axis_tready`.
- Accepted beat in SOP:
  - Clear the whole buffer, write the beat to slot 0, set beat index to 1.
  - Load `len_acc` with the popcount of tkeep.
  - Bytes whose keep bit is 0 are written as 0x00 in every slot.
- Accepted beat in CAPT: write to slot `idx`, add its popcount to `len_acc`, increment `idx`.
- Capture completes on the first accepted beat that has `tlast`, or that fills slot `NBEATS-1`:
  - Next cycle: `hdr_valid=1`, `hdr_len=len_acc` (including this beat), `hdr_pkt_num=pkt_cnt`.
  - `pkt_cnt` increments, wrapping modulo 2^`PKT_NUM_W`.
  - `hdr_trunc=1` if the completing beat lacked `tlast`.
- Next state after completion: SOP if `tlast`, else DRAIN. DRAIN returns to SOP on an accepted `tlast` beat.
- DRAIN beats never modify the header outputs.
- `hdr_valid` clears on `hdr_valid && hdr_ready`, unless a single-beat packet completes capture in that same cycle, in which case it stays 1 with the new contents.
- `hdr_data`, `hdr_len` and `hdr_trunc` are stable while `hdr_valid && !hdr_ready`.
- tkeep is contiguous from bit 0 and all-ones on non-last beats; `hdr_len` is defined only under this rule.

## Timing
- Reset values:
  - `st=SOP`, `pkt_cnt=0`.
  - `hdr_valid=0`, `hdr_data=0`, `hdr_len=0`, `hdr_trunc=0`, `hdr_pkt_num=0`.
  - `s_axis_tready` follows `m_axis_tready`, since `blk=0` after reset.
- Pass-through path: 0-cycle combinational latency, no buffering.
- Header latency: `hdr_valid` rises 1 cycle after the completing beat is accepted.
- Throughput:
  - Back-to-back single-beat packets run at 1 packet/cycle while `hdr_ready=1`.
  - A new packet's first beat is held only while the previous header is unconsumed.
- Reset mid-packet discards the partial capture. The next accepted beat is treated as SOP.
- Same-cycle events:
  - Header handshake plus SOP capture: the consumer samples the old registers, and the new beat writes at the same edge.

## Test plan
- Single 64-byte packet (1 beat, keep all-ones, tlast):
  - Next cycle `hdr_valid=1`, `hdr_len=64`, `hdr_trunc=0`, `hdr_pkt_num=0`, upper 3584 bits zero.
- 3-beat packet, last keep=0x0000_0000_0000_FFFF:
  - `hdr_len=144`, slot 2 bytes 16..63 zero, slots 3..7 zero.
- 10-beat packet:
  - Header after beat 8 with `hdr_len=512`, `hdr_trunc=1`.
  - Beats 9..10 forwarded on m_axis with header unchanged; return to SOP.
- `hdr_ready=0` held 5 cycles after packet A:
  - Packet B first beat stalls (`s_axis_tready=0`) until the handshake.
  - B captured with `hdr_pkt_num=1`; A fields stable throughout.
- 20 back-to-back 1-beat packets, `hdr_ready=1`:
  - 20 headers on consecutive cycles, `hdr_pkt_num` 0..19, no ingress stall.
- Reset asserted during beat 2 of a 4-beat packet:
  - All outputs return to reset values.
  - The next beat is captured as slot 0 with `hdr_pkt_num=0`.

Source files
------------

// File: rtl/prs_hdr_capture.sv
// Ingress header capture: forwards every beat to the packet store and snapshots the
// first NBEATS beats of each packet into a header buffer handed to the parser.
//
// state    | meaning
// ST_SOP   | next accepted beat starts a packet (slot 0)
// ST_CAPT  | capturing beats 1..NBEATS-1
// ST_DRAIN | past the header window, beats are forwarded only
module prs_hdr_capture #(
    parameter int DATA_W    = 512,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int BUFF_W    = 4096,
    parameter int LEN_W     = 32,
    parameter int PKT_NUM_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    s_axis_tdata,
    input  logic [KEEP_W-1:0]    s_axis_tkeep,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic [KEEP_W-1:0]    m_axis_tkeep,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [BUFF_W-1:0]    hdr_data,
    output logic [LEN_W-1:0]     hdr_len,
    output logic                 hdr_trunc,
    output logic [PKT_NUM_W-1:0] hdr_pkt_num,
    output logic                 hdr_valid,
    input  logic                 hdr_ready
);

    localparam int NBEATS = BUFF_W / DATA_W;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {ST_SOP, ST_CAPT, ST_DRAIN} st_e;

    st_e                  st_q, st_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BUFF_W-1:0]    data_q, data_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 trunc_q, trunc_d;
    logic                 valid_q, valid_d;
    logic [PKT_NUM_W-1:0] cnt_q, cnt_d;
    logic [PKT_NUM_W-1:0] num_q, num_d;

    logic                 blk;
    logic                 accept;
    logic                 done;
    logic [IDX_W-1:0]     slot;
    logic [DATA_W-1:0]    beat_masked;
    logic [LEN_W-1:0]     beat_len;

    // A new packet may not overwrite a header the parser has not taken yet.
    assign blk           = (st_q == ST_SOP) && valid_q && !hdr_ready;
    assign s_axis_tready = m_axis_tready && !blk;
    assign m_axis_tvalid = s_axis_tvalid && !blk;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        beat_masked = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            beat_masked[b*8 +: 8] = s_axis_tkeep[b] ? s_axis_tdata[b*8 +: 8] : 8'h00;
        end
        beat_len = LEN_W'($countones(s_axis_tkeep));
    end

    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        data_d  = data_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        done    = 1'b0;
        slot    = (st_q == ST_SOP) ? '0 : idx_q;

        if (valid_q && hdr_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            case (st_q)
                ST_SOP, ST_CAPT: begin
                    if (st_q == ST_SOP) begin
                        data_d = '0;
                        len_d  = beat_len;
                    end else begin
                        len_d  = len_q + beat_len;
                    end
                    data_d[DATA_W*32'(slot) +: DATA_W] = beat_masked;
                    idx_d = slot + IDX_W'(1);
                    done  = s_axis_tlast || (slot == IDX_W'(NBEATS - 1));
                    if (done) begin
                        valid_d = 1'b1;
                        trunc_d = !s_axis_tlast;
                        num_d   = cnt_q;
                        cnt_d   = cnt_q + PKT_NUM_W'(1);
                        st_d    = s_axis_tlast ? ST_SOP : ST_DRAIN;
                    end else begin
                        st_d    = ST_CAPT;
                    end
                end
                ST_DRAIN: begin
                    if (s_axis_tlast) begin
                        st_d = ST_SOP;
                    end
                end
                default: st_d = ST_SOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_SOP;
            idx_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            num_q   <= '0;
        end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
        end
    end

    assign hdr_data    = data_q;
    assign hdr_len     = len_q;
    assign hdr_trunc   = trunc_q;
    assign hdr_pkt_num = num_q;
    assign hdr_valid   = valid_q;

endmodule

// File: tb/tb_prs_hdr_capture.sv
// Bench for prs_hdr_capture: packet table plus hand-written stall, burst and reset
// sequences; expected headers are queued at send time and checked at each handshake.
module tb_prs_hdr_capture;

    localparam int DATA_W    = 512;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int BUFF_W    = 4096;
    localparam int LEN_W     = 32;
    localparam int PKT_NUM_W = 64;
    localparam int NB        = BUFF_W / DATA_W;

    typedef struct {
        logic [BUFF_W-1:0]    data;
        logic [LEN_W-1:0]     len;
        logic                 trunc;
        logic [PKT_NUM_W-1:0] num;
    } hdr_t;

    typedef struct {
        int                nbeats;
        logic [KEEP_W-1:0] last_keep;
        int                exp_len;
        logic              exp_trunc;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [DATA_W-1:0]    s_tdata = '0;
    logic [KEEP_W-1:0]    s_tkeep = '0;
    logic                 s_tvalid = 1'b0;
    logic                 s_tlast = 1'b0;
    logic                 s_tready;
    logic [DATA_W-1:0]    m_tdata;
    logic [KEEP_W-1:0]    m_tkeep;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready = 1'b1;
    logic [BUFF_W-1:0]    hdr_data;
    logic [LEN_W-1:0]     hdr_len;
    logic                 hdr_trunc;
    logic [PKT_NUM_W-1:0] hdr_pkt_num;
    logic                 hdr_valid;
    logic                 hdr_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [PKT_NUM_W-1:0] exp_pkt = '0;
    hdr_t sb[$];
    hdr_t last_exp;
    int pop_cyc[$];
    vec_t vecs[6];

    prs_hdr_capture #(
        .DATA_W(DATA_W), .KEEP_W(KEEP_W), .BUFF_W(BUFF_W),
        .LEN_W(LEN_W), .PKT_NUM_W(PKT_NUM_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .hdr_data(hdr_data), .hdr_len(hdr_len), .hdr_trunc(hdr_trunc),
        .hdr_pkt_num(hdr_pkt_num), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [BUFF_W-1:0] act,
                            input logic [BUFF_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int s = 0; s < NB; s++) begin
                if (act[s*DATA_W +: DATA_W] !== exp[s*DATA_W +: DATA_W]) begin
                    $display("FAIL %s slot %0d: got %h expected %h", nm, s,
                             act[s*DATA_W +: DATA_W], exp[s*DATA_W +: DATA_W]);
                    break;
                end
            end
        end
    endtask

    // Scoreboard: every header handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        hdr_t e;
        #2;
        if (!rst && hdr_valid && hdr_ready) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("hdr_unexpected", 64'(hdr_pkt_num), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk_data("hdr_data", hdr_data, e.data);
                chk("hdr_len", 64'(hdr_len), 64'(e.len));
                chk("hdr_trunc", 64'(hdr_trunc), 64'(e.trunc));
                chk("hdr_pkt_num", hdr_pkt_num, e.num);
            end
        end
    end

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                             input logic l, output int stalls);
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        stalls = 0;
        #1;
        while (!s_tready && stalls < 100) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (!s_tready) begin
            chk("beat_accept_timeout", 64'(s_tready), 64'd1);
        end else begin
            chk("pass_valid", 64'(m_tvalid), 64'd1);
            chk("pass_last", 64'(m_tlast), 64'(l));
            chk("pass_keep", m_tkeep, k);
            checks++;
            if (m_tdata !== d) begin
                errors++;
                $display("FAIL pass_data: got %h expected %h", m_tdata, d);
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [KEEP_W-1:0] lk, input int elen,
                            input logic etrunc, output int stalls);
        logic [DATA_W-1:0] beats [0:15];
        logic [KEEP_W-1:0] k;
        hdr_t              e;
        int                cap;
        int                st;
        cap = (n < NB) ? n : NB;
        e.data = '0;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < DATA_W / 32; w++) beats[i][w*32 +: 32] = $urandom();
            k = (i == n - 1) ? lk : '1;
            if (i < cap) begin
                for (int b = 0; b < KEEP_W; b++)
                    e.data[i*DATA_W + b*8 +: 8] = k[b] ? beats[i][b*8 +: 8] : 8'h00;
            end
        end
        e.len = LEN_W'(elen);
        e.trunc = etrunc;
        e.num = exp_pkt;
        exp_pkt = exp_pkt + 1;
        sb.push_back(e);
        last_exp = e;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            k = (i == n - 1) ? lk : '1;
            send_beat(beats[i], k, (i == n - 1), st);
            stalls += st;
            if (i == cap - 1) chk("hdr_latency", 64'(hdr_valid), 64'd1);
        end
    endtask

    initial begin
        int st;
        int tot;
        int a_num;
        logic [BUFF_W-1:0] a_data;
        logic [DATA_W-1:0] bx;

        vecs[0] = '{1,  {KEEP_W{1'b1}},            64,  1'b0};
        vecs[1] = '{3,  64'h0000_0000_0000_FFFF,   144, 1'b0};
        vecs[2] = '{10, {KEEP_W{1'b1}},            512, 1'b1};
        vecs[3] = '{8,  {KEEP_W{1'b1}},            512, 1'b0};
        vecs[4] = '{9,  64'h0000_0000_0000_0001,   512, 1'b1};
        vecs[5] = '{2,  64'h0000_0000_0000_0007,   67,  1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(hdr_valid), 64'd0);
        chk("rst_len", 64'(hdr_len), 64'd0);
        chk("rst_trunc", 64'(hdr_trunc), 64'd0);
        chk("rst_pkt_num", hdr_pkt_num, 64'd0);
        chk_data("rst_data", hdr_data, '0);
        chk("rst_tready_hi", 64'(s_tready), 64'd1);
        m_tready = 1'b0;
        #1;
        chk("rst_tready_lo", 64'(s_tready), 64'd0);
        m_tready = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            send_pkt(vecs[v].nbeats, vecs[v].last_keep, vecs[v].exp_len,
                     vecs[v].exp_trunc, st);
            @(negedge clk); @(negedge clk); #1;
            chk("hold_len", 64'(hdr_len), 64'(vecs[v].exp_len));
            chk("hold_trunc", 64'(hdr_trunc), 64'(vecs[v].exp_trunc));
            chk("hold_valid", 64'(hdr_valid), 64'd0);
            chk_data("hold_data", hdr_data, last_exp.data);
        end

        // Unconsumed header must hold off the next packet's first beat.
        @(negedge clk);
        hdr_ready = 1'b0;
        send_pkt(1, '1, 64, 1'b0, st);
        a_num = int'(exp_pkt) - 1;
        a_data = last_exp.data;
        fork
            begin
                send_pkt(1, '1, 64, 1'b0, st);
                chk("stall_seen", 64'(st > 0), 64'd1);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk); #1;
                    chk("stall_tready", 64'(s_tready), 64'd0);
                    chk("stall_mvalid", 64'(m_tvalid), 64'd0);
                    chk("stall_hvalid", 64'(hdr_valid), 64'd1);
                    chk("stall_num", hdr_pkt_num, 64'(a_num));
                    chk("stall_len", 64'(hdr_len), 64'd64);
                    chk_data("stall_data", hdr_data, a_data);
                end
                @(negedge clk);
                hdr_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);

        // Back-to-back single-beat packets.
        pop_cyc.delete();
        tot = 0;
        for (int i = 0; i < 20; i++) begin
            send_pkt(1, '1, 64, 1'b0, st);
            tot += st;
        end
        repeat (3) @(negedge clk);
        chk("burst_count", 64'(pop_cyc.size()), 64'd20);
        if (pop_cyc.size() == 20)
            chk("burst_span", 64'(pop_cyc[19] - pop_cyc[0]), 64'd19);
        chk("burst_stalls", 64'(tot), 64'd0);
        chk("burst_sb_empty", 64'(sb.size()), 64'd0);

        // Reset during beat 2 of a 4-beat packet.
        for (int w = 0; w < DATA_W / 32; w++) bx[w*32 +: 32] = $urandom();
        send_beat(bx, '1, 1'b0, st);
        s_tdata = ~bx; s_tkeep = '1; s_tlast = 1'b0; s_tvalid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = 1'b0;
        #1;
        chk("mrst_valid", 64'(hdr_valid), 64'd0);
        chk("mrst_len", 64'(hdr_len), 64'd0);
        chk("mrst_trunc", 64'(hdr_trunc), 64'd0);
        chk("mrst_pkt_num", hdr_pkt_num, 64'd0);
        chk_data("mrst_data", hdr_data, '0);
        chk("mrst_tready", 64'(s_tready), 64'd1);
        exp_pkt = '0;
        @(negedge clk);
        send_pkt(1, 64'h0000_0000_FFFF_FFFF, 32, 1'b0, st);
        repeat (5) @(negedge clk);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
